// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO with sticky overrun/frame flags.
// Define UART_RX_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizer.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    input  logic [DIV_W-1:0]                div,
    input  logic                            rd_en,
    output logic [7:0]                      rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overrun,
    output logic                            frame_err,
    input  logic                            clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, nxt;
    logic               s1, s2, line, line_d, fall, tick, push, ferr_set, wr, rd, full;
    logic [DIV_W-1:0]   div_l, cnt, tgt;
    logic [2:0]         bit_cnt;
    logic [7:0]         sh;
    logic [AW-1:0]      wp, rp;
    logic [7:0]         mem [FIFO_DEPTH];

    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2} <= 2'b11;
        else     {s1, s2} <= {rx, s1};

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hist <= 2'b11;
            line <= 1'b1;
        end else begin
            hist <= {hist[0], s2};
            line <= (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
        end
`else
    assign line = s2;
`endif

    assign fall = line_d & ~line;
    // START waits half a bit so every later sample lands mid-bit
    assign tgt  = (state == START) ? {1'b0, div_l[DIV_W-1:1]} : div_l;
    assign tick = (cnt == tgt - 1'b1);

    always_comb begin
        nxt      = state;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE:  nxt = fall ? START : IDLE;
            START: nxt = tick ? (line ? IDLE : DATA) : START;
            DATA:  nxt = (tick && bit_cnt == 3'd7) ? STOP : DATA;
            STOP: begin
                nxt      = tick ? IDLE : STOP;
                push     = tick & line;
                ferr_set = tick & ~line;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            line_d  <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            div_l   <= DIV_W'(4);
        end else begin
            state   <= nxt;
            line_d  <= line;
            cnt     <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            bit_cnt <= (state == IDLE) ? 3'd0 : (state == DATA && tick) ? bit_cnt + 3'd1 : bit_cnt;
            sh      <= (state == DATA && tick) ? {line, sh[7:1]} : sh;
            if (state == IDLE && fall)
                div_l <= (div < DIV_W'(4)) ? DIV_W'(4) : div;
        end

    assign full     = (level == LW'(FIFO_DEPTH));
    assign rd       = rd_en & rd_valid;
    // a full FIFO still accepts a byte when the same cycle frees a slot
    assign wr       = push & (~full | rd);
    assign rd_valid = (level != '0);
    assign rd_data  = rd_valid ? mem[rp] : 8'h00;

    always_ff @(posedge clk)
        if (wr) mem[wp] <= sh;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wp        <= wr ? wp + 1'b1 : wp;
            rp        <= rd ? rp + 1'b1 : rp;
            level     <= level + LW'(wr) - LW'(rd);
            overrun   <= (push & ~wr) ? 1'b1 : clr_err ? 1'b0 : overrun;
            frame_err <= ferr_set ? 1'b1 : clr_err ? 1'b0 : frame_err;
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized frames against a queue-based receive model, plus literal directed checks.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [15:0]   div = 16'd16;
    logic [7:0]    rd_data;
    logic          rd_valid, overrun, frame_err;
    logic [LW-1:0] level;

    int         n_chk = 0, n_fail = 0, cyc = 0;
    bit         settled = 1'b0;
    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0, exp_ferr = 1'b0;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .div(div), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .level(level), .overrun(overrun), .frame_err(frame_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model is compared whenever the line is idle and the last frame has fully resolved.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("valid_vs_level", 32'(rd_valid), 32'(level != 0));
            if (!rd_valid) chk("empty_data", 32'(rd_data), 0);
        end
        if (settled) begin
            chk("level", 32'(level), exp_q.size());
            chk("rd_data", 32'(rd_data), exp_q.size() != 0 ? 32'(exp_q[0]) : 0);
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            chk("frame_err", 32'(frame_err), 32'(exp_ferr));
        end
    end

    task automatic send(input logic [7:0] b, input bit stop, input int d, input bit pop_at, input bit wild_div);
        int k = 0;
        settled = 1'b0;
        @(negedge clk);
        div = wild_div ? 16'($urandom_range(0, 3)) : 16'(d);
        for (int c = 0; c < 11 * d + 6; c++) begin
            @(negedge clk);
            if (c == 0) k = cyc;
            rx = (c < d) ? 1'b0 : (c < 9 * d) ? b[3'((c - d) / d)] : (c < 10 * d) ? stop : 1'b1;
            if (c == 2 * d && !wild_div) div = 16'($urandom_range(0, 40));
            rd_en = pop_at && (cyc == k + LAT - 1 + d / 2 + 9 * d);
        end
        rd_en = 1'b0;
        if (pop_at && exp_q.size() != 0) void'(exp_q.pop_front());
        if (!stop) exp_ferr = 1'b1;
        else if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back(b);
        settled = 1'b1;
    endtask

    task automatic pop(input bit use_lit, input logic [7:0] lit);
        @(negedge clk);
        chk("pop_data", 32'(rd_data), exp_q.size() != 0 ? 32'(exp_q[0]) : 0);
        if (use_lit) chk("pop_literal", 32'(rd_data), 32'(lit));
        rd_en = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        clr_err  = 1'b1;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_flags", 32'({overrun, frame_err}), 0);
        rst = 1'b0;
        settled = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1, 16, 1'b0, 1'b0);
        chk("a5_valid", 32'(rd_valid), 1);
        chk("a5_data", 32'(rd_data), 32'h A5);
        chk("a5_level", 32'(level), 1);
        chk("a5_flags", 32'({overrun, frame_err}), 0);
        pop(1'b1, 8'hA5);

        send(8'h3C, 1'b0, 16, 1'b0, 1'b0);
        chk("3c_ferr", 32'(frame_err), 1);
        chk("3c_valid", 32'(rd_valid), 0);
        clr();
        @(negedge clk);
        chk("3c_cleared", 32'(frame_err), 0);

        div = 16'd16;
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch_level", 32'(level), 0);
        chk("glitch_flags", 32'({overrun, frame_err}), 0);

        for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 6, 1'b0, 1'b0);
        chk("ovr_level", 32'(level), 16);
        chk("ovr_flag", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) pop(1'b1, 8'(i));
        clr();

        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1, 6, 1'b0, 1'b0);
        send(8'h30, 1'b1, 6, 1'b1, 1'b0);
        chk("full_pop_level", 32'(level), 16);
        chk("full_pop_ovr", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) pop(1'b1, i < 15 ? 8'h21 + 8'(i) : 8'h30);
        pop(1'b0, 8'h00);

        send(8'h9A, 1'b1, 4, 1'b0, 1'b1);
        pop(1'b1, 8'h9A);

        settled = 1'b0;
        exp_q.push_back(8'h77);
        div = 16'd16;
        for (int c = 0; c < 5 * 16 + 8; c++) begin
            @(negedge clk);
            rx = (c < 16) ? 1'b0 : 1'b1;
        end
        rst = 1'b1;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        settled = 1'b1;
        @(negedge clk);
        chk("rst_mid_level", 32'(level), 0);
        send(8'h55, 1'b1, 16, 1'b0, 1'b0);
        chk("rst_55_level", 32'(level), 1);
        chk("rst_55_data", 32'(rd_data), 32'h55);

        for (int n = 0; n < 60; n++) begin
            send(8'($urandom), $urandom_range(0, 9) != 0, $urandom_range(4, 24), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) pop(1'b0, 8'h00);
            if ($urandom_range(0, 7) == 0) clr();
        end
        while (exp_q.size() != 0) pop(1'b0, 8'h00);
        pop(1'b0, 8'h00);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
